// File: rtl/ccsds_turbo_enc_rsc_if.sv
// Encoder-side bundle: block control, info-buffer read port and the coded symbol stream.
// master = encoder, slave = buffer/consumer side.
interface ccsds_turbo_enc_rsc_if #(
   parameter int AW = 14
);
   logic          i_start;
   logic          o_busy;
   logic          o_read;
   logic [AW-1:0] o_idx;
   logic          i_data;
   logic          o_valid;
   logic          o_sys;
   logic [2:0]    o_par;
   logic          o_tail;
   logic          o_last;
   logic          o_done;

   modport master (
      input  i_start, i_data,
      output o_busy, o_read, o_idx, o_valid, o_sys, o_par, o_tail, o_last, o_done
   );

   modport slave (
      output i_start, i_data,
      input  o_busy, o_read, o_idx, o_valid, o_sys, o_par, o_tail, o_last, o_done
   );
endinterface

// File: rtl/ccsds_turbo_enc_rsc.sv
// CCSDS 16-state RSC constituent encoder: K info symbols then 4 tail symbols, symbol n valid 2 cycles
// after its read, no backpressure. CCSDS_TURBO_RSC_RUNTIME_K_EN adds a per-block length input i_k.
module ccsds_turbo_enc_rsc #(
   parameter int K  = 8920,
   parameter int AW = 14
) (
   input  logic          clk,
   input  logic          rst,
`ifdef CCSDS_TURBO_RSC_RUNTIME_K_EN
   input  logic [AW-1:0] i_k,
`endif
   ccsds_turbo_enc_rsc_if.master bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_TAIL  = 2'd3;

   logic [1:0]    state;
   logic [AW-1:0] idx;
   logic [AW-1:0] last_idx;
   logic [1:0]    tcnt;
   logic          rd;
   logic          rd_q;
   logic          busy;
   logic [1:4]    d;
   logic          vld;
   logic          sys;
   logic [2:0]    par;
   logic          tail;
   logic          last;

   logic          accept;
   logic          step;
   logic          u;
   logic          a;
   logic [2:0]    par_n;

`ifdef CCSDS_TURBO_RSC_RUNTIME_K_EN
   localparam logic [AW-1:0] K_W = AW'(K);

   // Out-of-range lengths fall back to the build-time maximum.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_idx <= K_W - AW'(1);
      end else if (accept) begin
         last_idx <= ((i_k == '0) || (i_k > K_W)) ? K_W - AW'(1) : i_k - AW'(1);
      end
   end
`else
   assign last_idx = AW'(K - 1);
`endif

   assign accept = (state == S_IDLE) && bus.i_start && !busy;
   // rd_q marks the cycle a requested buffer bit is on i_data.
   assign step   = rd_q || (state == S_TAIL);

   always_comb begin
      u     = (state == S_TAIL) ? (d[3] ^ d[4]) : bus.i_data;
      a     = u ^ d[3] ^ d[4];
      par_n = {a ^ d[1] ^ d[2] ^ d[3] ^ d[4],
               a ^ d[2] ^ d[4],
               a ^ d[1] ^ d[3] ^ d[4]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         idx   <= '0;
         tcnt  <= '0;
         rd    <= 1'b0;
         rd_q  <= 1'b0;
         busy  <= 1'b0;
         d     <= '0;
         vld   <= 1'b0;
         sys   <= 1'b0;
         par   <= '0;
         tail  <= 1'b0;
         last  <= 1'b0;
      end else begin
         rd_q <= rd;
         vld  <= step;
         sys  <= step & u;
         par  <= step ? par_n : 3'b000;
         tail <= (state == S_TAIL);
         last <= (state == S_TAIL) && (tcnt == 2'd3);
         if (step) d <= {a, d[1:3]};
         if (accept)    busy <= 1'b1;
         else if (last) busy <= 1'b0;

         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_RUN;
                  rd    <= 1'b1;
                  idx   <= '0;
                  d     <= '0;
               end
            end
            S_RUN: begin
               if (idx == last_idx) begin
                  state <= S_FLUSH;
                  rd    <= 1'b0;
                  idx   <= '0;
               end else begin
                  idx <= idx + AW'(1);
               end
            end
            S_FLUSH: begin
               state <= S_TAIL;
               tcnt  <= '0;
            end
            default: begin
               tcnt <= tcnt + 2'd1;
               if (tcnt == 2'd3) state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_busy  = busy;
   assign bus.o_read  = rd;
   assign bus.o_idx   = idx;
   assign bus.o_valid = vld;
   assign bus.o_sys   = sys;
   assign bus.o_par   = par;
   assign bus.o_tail  = tail;
   assign bus.o_last  = last;
   assign bus.o_done  = last;
endmodule

// File: tb/tb_ccsds_turbo_enc_rsc.sv
// Bench for ccsds_turbo_enc_rsc: buffer responder, symbol monitor and a polynomial-form reference encoder.
module tb_ccsds_turbo_enc_rsc;
   localparam int K  = 16;
   localparam int AW = 14;
   localparam int N  = K + 4;
   localparam logic [4:0] G1 = 5'b11011;
   localparam logic [4:0] G2 = 5'b10101;
   localparam logic [4:0] G3 = 5'b11111;

   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef CCSDS_TURBO_RSC_RUNTIME_K_EN
   logic [AW-1:0] i_k = '0;
`endif

   ccsds_turbo_enc_rsc_if #(.AW(AW)) bus ();

   ccsds_turbo_enc_rsc #(.K(K), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
`ifdef CCSDS_TURBO_RSC_RUNTIME_K_EN
      .i_k (i_k),
`endif
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int first_rd     = -1;
   int done_cyc     = -1;
   int done_cnt     = 0;

   logic       mem     [K];
   logic       mem_sav [K];
   logic       ref_a   [N];
   logic [6:0] exp_sym [N];
   logic [6:0] sym_q   [$];
   int         idx_q   [$];

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Buffer: data for a read seen in cycle t is presented throughout cycle t+1, junk otherwise.
   initial begin
      logic rq;
      int   ri;
      bus.i_data = 1'b0;
      forever begin
         @(negedge clk);
         rq = bus.o_read;
         ri = int'(bus.o_idx);
         @(posedge clk);
         #1;
         bus.i_data = (rq && ri < K) ? mem[ri] : 1'($urandom);
      end
   end

   always @(negedge clk) begin
      if (bus.o_valid)
         sym_q.push_back({bus.o_sys, bus.o_par, bus.o_tail, bus.o_last, bus.o_done});
      if (bus.o_read) begin
         if (idx_q.size() == 0) first_rd = cyc;
         idx_q.push_back(int'(bus.o_idx));
      end
      if (bus.o_done) begin
         done_cyc = cyc;
         done_cnt++;
      end
   end

   function automatic logic av(input int n);
      return (n >= 0) ? ref_a[n] : 1'b0;
   endfunction

   function automatic logic conv(input logic [4:0] g, input int n);
      logic r = 1'b0;
      for (int k = 0; k < 5; k++)
         if (g[k]) r ^= av(n - k);
      return r;
   endfunction

   // a(D) = u(D)/G0(D); parity j = a(D)*Gj(D); tail input cancels the feedback.
   task automatic build_model();
      logic fb, u;
      for (int n = 0; n < N; n++) begin
         fb       = av(n - 3) ^ av(n - 4);
         u        = (n < K) ? mem[n] : fb;
         ref_a[n] = u ^ fb;
         exp_sym[n] = {u, conv(G3, n), conv(G2, n), conv(G1, n),
                       (n >= K), (n == N - 1), (n == N - 1)};
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic start_block(output int s);
      sym_q.delete();
      idx_q.delete();
      done_cnt    = 0;
      first_rd    = -1;
      done_cyc    = -1;
      bus.i_start = 1'b1;
      s           = cyc;
      tick();
      bus.i_start = 1'b0;
   endtask

   task automatic finish_block(input string tag, input int s);
      int guard = 0;
      int bad   = 0;
      while (done_cnt == 0 && guard < 200) begin
         tick();
         guard++;
      end
      chk($sformatf("%s_done_seen", tag), done_cnt, 1);
      chk($sformatf("%s_busy_at_done", tag), bus.o_busy, 1'b1);
      chk($sformatf("%s_sym_count", tag), sym_q.size(), N);
      chk($sformatf("%s_first_rd", tag), first_rd, s + 1);
      chk($sformatf("%s_done_cyc", tag), done_cyc, s + K + 6);
      chk($sformatf("%s_rd_count", tag), idx_q.size(), K);
      for (int i = 0; i < idx_q.size(); i++)
         if (idx_q[i] != i) bad++;
      chk($sformatf("%s_rd_order", tag), bad, 0);
      for (int n = 0; n < N; n++)
         chk($sformatf("%s_sym%0d", tag, n),
             (n < sym_q.size()) ? {25'd0, sym_q[n]} : 32'hxxxx_xxxx, {25'd0, exp_sym[n]});
   endtask

   function automatic logic [31:0] out_vec();
      return {8'd0, bus.o_read, bus.o_idx, bus.o_valid, bus.o_sys, bus.o_par,
              bus.o_tail, bus.o_last, bus.o_done, bus.o_busy};
   endfunction

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int s;
      bus.i_start = 1'b0;
      foreach (mem[i]) mem[i] = 1'b0;

      rst = 1'b1;
      tick(3);
      chk("reset_outputs", out_vec(), 32'd0);
      rst = 1'b0;
      tick(2);
      chk("idle_outputs", out_vec(), 32'd0);

      // 1: all-zero block
      build_model();
      start_block(s);
      finish_block("t1_zero", s);
      tick(2);

      // 2: single leading one
      mem[0] = 1'b1;
      build_model();
      start_block(s);
      finish_block("t2_impulse", s);
      chk("t2_s0", sym_q[0][6:3], 4'b1111);
      chk("t2_s1", sym_q[1][6:3], 4'b0101);
      chk("t2_s2", sym_q[2][6:3], 4'b0110);
      tick(3);

      // 3: random block
      foreach (mem[i]) mem[i] = 1'($urandom);
      mem_sav = mem;
      build_model();
      start_block(s);
      finish_block("t3_random", s);
      tick(2);

      // 5: stray i_start during RUN must not disturb the block
      mem = mem_sav;
      build_model();
      start_block(s);
      tick(5);
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      finish_block("t5_stray_start", s);
      tick(2);

      // 4: back-to-back blocks, second start the cycle busy drops
      foreach (mem[i]) mem[i] = 1'($urandom);
      build_model();
      start_block(s);
      finish_block("t4_blk_a", s);
      tick();
      chk("t4_busy_low", bus.o_busy, 1'b0);
      foreach (mem[i]) mem[i] = 1'($urandom);
      build_model();
      start_block(s);
      finish_block("t4_blk_b", s);
      tick(2);

      // 6: reset in the 8th RUN cycle, then a clean block
      foreach (mem[i]) mem[i] = 1'($urandom);
      build_model();
      start_block(s);
      tick(7);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_after_rst", out_vec(), 32'd0);
      sym_q.delete();
      tick(10);
      chk("t6_no_syms", sym_q.size(), 0);
      chk("t6_idle_outputs", out_vec(), 32'd0);
      foreach (mem[i]) mem[i] = 1'($urandom);
      build_model();
      start_block(s);
      finish_block("t6_post_rst", s);
      tick(3);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
